// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the multiply/divide unit.
//   div_state_t  - divider sequencer states
//   DIV_WIDTH    - default operand/result width
//   DIV_CNT_W    - step-counter width for the default width
//   div_cnt_w()  - step-counter width for an arbitrary width
package mdu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } div_state_t;

  localparam int unsigned DIV_WIDTH = 32;

  function automatic int unsigned div_cnt_w(input int unsigned w);
    return $clog2(w);
  endfunction

  localparam int unsigned DIV_CNT_W = div_cnt_w(DIV_WIDTH);

endpackage

// File: rtl/mdu_div_if.sv
// mdu_div_if: request/response bundle between the execute stage and the
// divider.
//   start, sign, a, b  - request (master -> slave)
//   busy, done, q, r, dz - status and result (slave -> master)
interface mdu_div_if
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
);

  logic             start;
  logic             sign;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dz;

  modport master (
    output start, sign, a, b,
    input  busy, done, q, r, dz
  );

  modport slave (
    input  start, sign, a, b,
    output busy, done, q, r, dz
  );

endinterface

// File: rtl/mdu_div_step.sv
// div_step: one combinational restoring-division iteration.
//   rem      - current partial remainder (WIDTH+1 bits)
//   bit_in   - next dividend bit shifted into the remainder
//   divisor  - divisor magnitude
//   rem_next - partial remainder after the trial subtraction
//   q_bit    - resulting quotient bit
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_next,
  output logic             q_bit
);

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;

  // The partial remainder is always below the divisor, so the shifted
  // value stays under 2^(WIDTH+1) and diff's MSB is a clean borrow flag.
  always_comb begin
    shifted  = {rem, bit_in};
    diff     = shifted - {2'b00, divisor};
    q_bit    = ~diff[WIDTH+1];
    rem_next = q_bit ? diff[WIDTH:0] : shifted[WIDTH:0];
  end

endmodule

// File: rtl/mdu_div.sv
// mdu_div: iterative signed/unsigned restoring divider, fixed WIDTH+1
// edge latency from accept to done.
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - mdu_div_if slave: start/sign/a/b in, busy/done/q/r/dz out
module mdu_div
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input logic      clk,
  input logic      rst,
  mdu_div_if.slave bus
);

  localparam int unsigned CW = div_cnt_w(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div;
  logic [WIDTH-1:0] a_orig;
  logic             neg_q;
  logic             neg_r;
  logic             dz_l;

  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic [WIDTH:0]   rem_next;
  logic             q_bit;

  // Magnitudes wrap the most negative value onto 2^(WIDTH-1) unsigned.
  always_comb begin
    a_mag = (bus.sign && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag = (bus.sign && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    q_fix = neg_q ? -quo : quo;
    r_fix = neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem),
    .bit_in   (quo[WIDTH-1]),
    .divisor  (div),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      div      <= '0;
      a_orig   <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dz_l     <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.q    <= '0;
      bus.r    <= '0;
      bus.dz   <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            neg_q    <= bus.sign & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
            neg_r    <= bus.sign & bus.a[WIDTH-1];
            dz_l     <= (bus.b == '0);
            a_orig   <= bus.a;
            quo      <= a_mag;
            div      <= b_mag;
            rem      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // quo doubles as the dividend shift register: its MSB feeds the
          // step while quotient bits enter at the LSB.
          rem <= rem_next;
          quo <= {quo[WIDTH-2:0], q_bit};
          cnt <= cnt + CW'(1);
          if (cnt == CNT_LAST) state <= FIX;
        end
        FIX: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b1;
          bus.dz   <= dz_l;
          bus.q    <= dz_l ? '1 : q_fix;
          bus.r    <= dz_l ? a_orig : r_fix;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_div.sv
// tb_mdu_div: directed self-checking bench for mdu_div (WIDTH=32).
module tb_mdu_div;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  mdu_div_if #(.WIDTH(32)) bus ();

  mdu_div #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge. Issues one request, optionally pulses a stray
  // start (9/3) glitch_at cycles after accept, waits for done, and checks
  // latency, busy duration and results. Returns at the done-cycle negedge
  // so the next call asserts start in the done cycle.
  task automatic run_op(input string tag, input logic s, input logic [31:0] av,
                        input logic [31:0] bv, input logic [31:0] eq,
                        input logic [31:0] er, input logic edz,
                        input int unsigned glitch_at);
    int unsigned k;
    int unsigned nbusy;
    bit seen;
    bus.start = 1'b1;
    bus.sign  = s;
    bus.a     = av;
    bus.b     = bv;
    @(negedge clk);
    bus.start = 1'b0;
    bus.sign  = ~s;
    bus.a     = ~av;
    bus.b     = bv ^ 32'h5;
    check({tag, ".done_low_after_accept"}, {31'd0, bus.done}, 32'd0);
    k = 0;
    nbusy = 0;
    seen = 1'b0;
    while (!seen && k < 100) begin
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        if (bus.busy) nbusy++;
        k++;
        bus.start = (glitch_at != 0 && k == glitch_at);
        if (bus.start) begin
          bus.a = 32'd9;
          bus.b = 32'd3;
        end
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    check({tag, ".done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, ".latency"}, k, 32'd33);
    check({tag, ".busy_cycles"}, nbusy, 32'd33);
    check({tag, ".busy_in_done"}, {31'd0, bus.busy}, 32'd0);
    check({tag, ".q"}, bus.q, eq);
    check({tag, ".r"}, bus.r, er);
    check({tag, ".dz"}, {31'd0, bus.dz}, {31'd0, edz});
  endtask

  initial begin
    int unsigned ndone;
    bus.start = 1'b0;
    bus.sign  = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    check("rst.busy", {31'd0, bus.busy}, 32'd0);
    check("rst.done", {31'd0, bus.done}, 32'd0);
    check("rst.q", bus.q, 32'd0);
    check("rst.r", bus.r, 32'd0);
    check("rst.dz", {31'd0, bus.dz}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("u100_7",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 0);
    run_op("s-7_2",    1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0, 0);
    run_op("uffff_1",  1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 0);
    run_op("s7_-2",    1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0, 0);
    run_op("s-7_-2",   1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF,  1'b0, 0);
    run_op("dz_u",     1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 0);
    run_op("dz_s",     1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1, 0);
    run_op("dz_sneg",  1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1, 0);
    run_op("ovf",      1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0, 0);
    run_op("ignore",   1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 5);
    run_op("b2b_9_3",  1'b0, 32'd9,          32'd3,          32'd3,          32'd0,          1'b0, 0);

    // Reset mid-operation, with start also held in the reset cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.sign  = 1'b0;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    check("midrst.busy", {31'd0, bus.busy}, 32'd0);
    check("midrst.q", bus.q, 32'd0);
    check("midrst.r", bus.r, 32'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) ndone++;
      if (bus.busy) ndone++;
      @(negedge clk);
    end
    check("midrst.no_done_or_busy", ndone, 32'd0);
    run_op("post_rst", 1'b0, 32'd20, 32'd6, 32'd3, 32'd2, 1'b0, 0);

    @(negedge clk);
    check("done_one_cycle", {31'd0, bus.done}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_div.md
# mdu_div

Iterative multi-cycle integer divider for the execute stage. It produces the quotient and remainder that the single-cycle ALU does not compute. Signed and unsigned division are handled explicitly, with fixed latency and a start/done handshake. It sits beside the ALU and is selected by the decode stage for DIV/DIVU/REM/REMU; the pipeline stalls while `busy` is high.

## Interface
- `WIDTH`, 32, operand/result width (≥ 2)
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  request; sampled only in IDLE
- `sign`  in  1  1 = signed (two's complement), 0 = unsigned; captured with `start`
- `a`  in  WIDTH  dividend; captured with `start`
- `b`  in  WIDTH  divisor; captured with `start`
- `busy`  out  1  high from the cycle after `start` is accepted until `done`
- `done`  out  1  one-cycle pulse; `q`/`r`/`dz` valid
- `q`  out  WIDTH  quotient; held until the next `done`
- `r`  out  WIDTH  remainder; held until the next `done`
- `dz`  out  1  divisor was zero; held with `q`/`r`

## Operation
- States: IDLE, RUN, FIX.
  - IDLE → RUN on `start`.
  - RUN → FIX when the step counter reaches WIDTH−1.
  - FIX → IDLE unconditionally.
- On accept (IDLE & `start`):
  - Latch `neg_q = sign & (a[W-1] ^ b[W-1])`, `neg_r = sign & a[W-1]`, and `dz = (b == 0)`.
  - Load magnitudes |a| and |b| (negate if `sign` and MSB set; the most negative value maps to 2^(W-1) unsigned).
  - Clear the partial remainder (W+1 bits) and the counter.
- RUN performs one restoring step per cycle:
  - Shift {rem, quo} left one bit, bringing in the next dividend MSB.
  - Trial-subtract |b|.
  - If the result is non-negative, keep it and set the quotient LSB to 1; otherwise restore and set it to 0.
- FIX drives the registered outputs:
  - If `dz`: `q` = all ones, `r` = original `a`.
  - Otherwise: `q` = `neg_q` ? −quo : quo, and `r` = `neg_r` ? −rem : rem.
- Signed overflow (−2^(W-1) / −1) needs no special case: it yields `q` = 0x80000000 and `r` = 0 naturally.
- `start` while `busy` is ignored; operands are not re-captured.
- `a`/`b`/`sign` may change after the accept cycle without effect.

## Timing
- Reset values: `busy`=0, `done`=0, `q`=0, `r`=0, `dz`=0, state IDLE, counter 0.
- Let E0 be the edge that samples `start`.
  - RUN occupies edges E1..E(W).
  - FIX is the cycle after E(W); outputs and `done`=1 are registered at E(W+1).
  - `done` is high for exactly one cycle, E(W+1)..E(W+2).
- Fixed latency of W+1 edges (33 for W=32), independent of operand values, including divide-by-zero.
- `busy` is 1 from E0 through E(W+1), and 0 in the cycle `done` is high.
  - A new `start` may be asserted in the `done` cycle and is accepted at E(W+2).
- `rst` mid-operation: the next edge returns to IDLE, clears all outputs, and no `done` is issued.
- `rst` has priority over `start` in the same cycle.

## Structure
- Shared package `mdu_pkg`:
  - State enum `div_state_t` {IDLE, RUN, FIX}
  - Default `WIDTH`
  - Counter width `$clog2(WIDTH)`
- Sub-module `div_step`: a combinational single restoring iteration.
  - Inputs: rem, next dividend bit, divisor.
  - Outputs: new rem, quotient bit.
  - Instantiated once inside `mdu_div`.
- Magnitude/negate logic stays inline.

## Test plan
- Unsigned: `a`=100, `b`=7, `sign`=0 → after 33 edges `done`=1, `q`=14, `r`=2, `dz`=0; `busy` high for exactly 33 cycles.
- Signed: `a`=0xFFFFFFF9 (−7), `b`=2, `sign`=1 → `q`=0xFFFFFFFD (−3), `r`=0xFFFFFFFF (−1); repeat unsigned with 0xFFFFFFFF/1 → `q`=0xFFFFFFFF, `r`=0.
- Divide-by-zero: `a`=5, `b`=0, either `sign` → `q`=0xFFFFFFFF, `r`=5, `dz`=1, same 33-edge latency.
- Overflow: `a`=0x80000000, `b`=0xFFFFFFFF, `sign`=1 → `q`=0x80000000, `r`=0, `dz`=0.
- Busy-ignore: start 100/7, pulse `start` with 9/3 at cycle 5 → result still `q`=14, `r`=2; back-to-back `start` in the `done` cycle → second op accepted, completes 33 edges later.
- Reset mid-op: assert `rst` 10 cycles after accept → next cycle `busy`=0, `q`=`r`=0, no `done` pulse in the following 40 cycles; a new op 20/6 then gives `q`=3, `r`=2.
